// File: rtl/music_pkg.sv
// Shared audio types and I2S framing constants for the sampler datapath.
package music_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int I2S_SLOT_W = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// 2-FF synchroniser for an edge-detected clock pin plus W plain data pins.
// Rise/fall strobes come from the edge pin only and are single-cycle.
module i2s_edge_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         edge_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         rise_o,
  output logic         fall_o
);

  logic         edge_meta_q, edge_sync_q, edge_prev_q;
  logic [W-1:0] data_meta_q, data_sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      edge_meta_q <= 1'b0;
      edge_sync_q <= 1'b0;
      edge_prev_q <= 1'b0;
      data_meta_q <= '0;
      data_sync_q <= '0;
    end else begin
      edge_meta_q <= edge_i;
      edge_sync_q <= edge_meta_q;
      edge_prev_q <= edge_sync_q;
      data_meta_q <= data_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign data_o = data_sync_q;
  assign rise_o = edge_sync_q & ~edge_prev_q;
  assign fall_o = ~edge_sync_q & edge_prev_q;

endmodule

// File: rtl/i2s_transceiver.sv
// I2S slave transceiver on the system clock: codec drives BCLK/LRCLK.
// Define I2S_LOOPBACK_EN to add loopback_sel (TX reloads from the RX pair).
module i2s_transceiver
  import music_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int SLOT_W = I2S_SLOT_W
) (
  input  logic              Clk,
  input  logic              Reset_h,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_adcdat,
  output logic              i2s_dacdat,
  output logic [DATA_W-1:0] rx_left,
  output logic [DATA_W-1:0] rx_right,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  output logic              tx_load
`ifdef I2S_LOOPBACK_EN
  ,
  input  logic              loopback_sel
`endif
);

  if (SLOT_W < DATA_W + 1) begin : g_bad_slot
    $error("i2s_transceiver: SLOT_W must be at least DATA_W+1");
  end

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] SLOT_MAX  = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);

  logic [1:0] side_sync;
  logic       bclk_rise, bclk_fall, lrclk_s, adc_s;

  i2s_edge_sync #(.W(2)) u_sync (
    .clk_i  (Clk),
    .rst_i  (Reset_h),
    .edge_i (i2s_bclk),
    .data_i ({i2s_adcdat, i2s_lrclk}),
    .data_o (side_sync),
    .rise_o (bclk_rise),
    .fall_o (bclk_fall)
  );

  assign lrclk_s = side_sync[0];
  assign adc_s   = side_sync[1];

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              lr_prev_q, framed_q, have_left_q, rx_valid_q;
  chan_t             chan_q;
  logic [DATA_W-2:0] rx_sr_q;
  logic [DATA_W-1:0] rx_word_d, rx_left_q, rx_right_q;
  logic              boundary, capture, word_done;

  always_comb begin
    boundary  = bclk_rise && (lrclk_s != lr_prev_q);
    bit_cnt_d = (bit_cnt_q == SLOT_MAX) ? bit_cnt_q : bit_cnt_q + 1'b1;
    // framed_q keeps a slot already in progress at reset from being captured
    capture   = bclk_rise && !boundary && framed_q && (bit_cnt_d <= DATA_LAST);
    word_done = capture && (bit_cnt_d == DATA_LAST);
    rx_word_d = {rx_sr_q, adc_s};
  end

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      bit_cnt_q   <= '0;
      lr_prev_q   <= 1'b0;
      chan_q      <= CH_LEFT;
      framed_q    <= 1'b0;
      have_left_q <= 1'b0;
      rx_sr_q     <= '0;
      rx_left_q   <= '0;
      rx_right_q  <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (boundary) begin
        bit_cnt_q <= '0;
        lr_prev_q <= lrclk_s;
        chan_q    <= chan_t'(lrclk_s);
        framed_q  <= 1'b1;
      end else if (bclk_rise) begin
        bit_cnt_q <= bit_cnt_d;
      end
      if (capture) rx_sr_q <= rx_word_d[DATA_W-2:0];
      if (word_done) begin
        if (chan_q == CH_LEFT) begin
          rx_left_q   <= rx_word_d;
          have_left_q <= 1'b1;
        end else if (have_left_q) begin
          rx_right_q  <= rx_word_d;
          rx_valid_q  <= 1'b1;
          have_left_q <= 1'b0;
        end
      end
    end
  end

  logic [DATA_W-1:0] tx_hold_l_q, tx_hold_r_q, load_l, load_r, tx_word;
  logic [DATA_W-2:0] tx_sr_q;
  logic [CNT_W-1:0]  tx_cnt_q;
  logic              tx_first_q, dacdat_q;

`ifdef I2S_LOOPBACK_EN
  assign load_l = loopback_sel ? rx_left_q  : tx_left;
  assign load_r = loopback_sel ? rx_right_q : tx_right;
`else
  assign load_l = tx_left;
  assign load_r = tx_right;
`endif

  assign tx_load = boundary && !lrclk_s;
  assign tx_word = (chan_q == CH_RIGHT) ? tx_hold_r_q : tx_hold_l_q;

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      tx_hold_l_q <= '0;
      tx_hold_r_q <= '0;
      tx_sr_q     <= '0;
      tx_cnt_q    <= '0;
      tx_first_q  <= 1'b0;
      dacdat_q    <= 1'b0;
    end else begin
      if (tx_load) begin
        tx_hold_l_q <= load_l;
        tx_hold_r_q <= load_r;
      end
      if (boundary) begin
        tx_first_q <= 1'b1;
      end else if (bclk_fall) begin
        if (tx_first_q) begin
          tx_sr_q    <= tx_word[DATA_W-2:0];
          dacdat_q   <= tx_word[DATA_W-1];
          tx_cnt_q   <= CNT_W'(1);
          tx_first_q <= 1'b0;
        end else if (tx_cnt_q < DATA_LAST) begin
          dacdat_q <= tx_sr_q[DATA_W-2];
          tx_sr_q  <= {tx_sr_q[DATA_W-3:0], 1'b0};
          tx_cnt_q <= tx_cnt_q + 1'b1;
        end else begin
          dacdat_q <= 1'b0;
        end
      end
    end
  end

  assign i2s_dacdat = dacdat_q;
  assign rx_left    = rx_left_q;
  assign rx_right   = rx_right_q;
  assign rx_valid   = rx_valid_q;

endmodule

// File: tb/tb_i2s_transceiver.sv
// Codec-side model driving I2S frames into i2s_transceiver, checked against a
// frame-level reference (expected pairs queue, expected DAC words per slot).
module tb_i2s_transceiver;

  localparam int DW   = 16;
  localparam int SLOT = 32;

  logic        Clk = 1'b0;
  logic        Reset_h = 1'b1;
  logic        bclk = 1'b0, lrclk = 1'b0, adcdat = 1'b0;
  logic        dacdat, rx_valid, tx_load;
  logic [15:0] rx_left, rx_right;
  logic [15:0] tx_left = 16'h0, tx_right = 16'h0;
  logic        lb_on = 1'b0;

  int total = 0;
  int bad   = 0;
  int half  = 163;

  i2s_transceiver dut (
    .Clk        (Clk),
    .Reset_h    (Reset_h),
    .i2s_bclk   (bclk),
    .i2s_lrclk  (lrclk),
    .i2s_adcdat (adcdat),
    .i2s_dacdat (dacdat),
    .rx_left    (rx_left),
    .rx_right   (rx_right),
    .rx_valid   (rx_valid),
    .tx_left    (tx_left),
    .tx_right   (tx_right),
    .tx_load    (tx_load)
`ifdef I2S_LOOPBACK_EN
    ,
    .loopback_sel (lb_on)
`endif
  );

  always #10 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  // reference model state
  pair_t       exp_q[$];
  pair_t       mon_p;
  logic        m_lr_prev;
  bit          m_slot_ok, m_have_left;
  logic [15:0] m_rxl, m_rxr, m_hold_l, m_hold_r;
  int          exp_loads = 0;
  int          got_loads = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    Reset_h = 1'b1;
    #100;
    check_eq("rst_dacdat",   32'(dacdat),   32'h0);
    check_eq("rst_rx_left",  32'(rx_left),  32'h0);
    check_eq("rst_rx_right", 32'(rx_right), 32'h0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_eq("rst_tx_load",  32'(tx_load),  32'h0);
    Reset_h     = 1'b0;
    m_lr_prev   = 1'b0;
    m_slot_ok   = 1'b0;
    m_have_left = 1'b0;
    m_rxl       = '0;
    m_rxr       = '0;
    m_hold_l    = '0;
    m_hold_r    = '0;
  endtask

  // One channel slot of nbits BCLK periods with one-bit I2S delay.
  task automatic slot(input bit ch, input logic [15:0] word, input int nbits, input int rst_k);
    logic [15:0] dac_word;
    bit          pad_ok;
    dac_word  = '0;
    pad_ok    = 1'b1;
    m_slot_ok = (ch != m_lr_prev);
    m_lr_prev = ch;
    if (m_slot_ok && !ch) begin
      exp_loads++;
      if (lb_on) begin
        m_hold_l = m_rxl;
        m_hold_r = m_rxr;
      end else begin
        m_hold_l = tx_left;
        m_hold_r = tx_right;
      end
    end
    for (int k = 0; k < nbits; k++) begin
      bclk = 1'b0;
      if (k == 0) lrclk = ch;
      adcdat = (k >= 1 && k <= DW) ? word[DW-k] : 1'($urandom);
      #(half);
      if (k >= 1 && k <= DW) dac_word[DW-k] = dacdat;
      else if (k > DW && dacdat !== 1'b0) pad_ok = 1'b0;
      bclk = 1'b1;
      if (m_slot_ok && k == DW) begin
        if (!ch) begin
          m_rxl       = word;
          m_have_left = 1'b1;
        end else if (m_have_left) begin
          exp_q.push_back('{l: m_rxl, r: word});
          m_rxr       = word;
          m_have_left = 1'b0;
        end
      end
      if (k == rst_k) begin
        pulse_reset();
        #(half - 100);
      end else begin
        #(half);
      end
    end
    if (m_slot_ok && nbits == SLOT) begin
      check_eq(ch ? "dac_right" : "dac_left", 32'(dac_word), 32'(ch ? m_hold_r : m_hold_l));
      check_eq("dac_pad_zero", 32'(pad_ok), 32'h1);
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    slot(1'b0, l, SLOT, -1);
    slot(1'b1, r, SLOT, -1);
  endtask

  task automatic rand_tx();
    tx_left  = 16'($urandom);
    tx_right = 16'($urandom);
  endtask

  always @(negedge Clk) begin
    if (!Reset_h && rx_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rx_spurious", 32'(rx_valid), 32'h0);
      end else begin
        mon_p = exp_q.pop_front();
        check_eq("rx_left",  32'(rx_left),  32'(mon_p.l));
        check_eq("rx_right", 32'(rx_right), 32'(mon_p.r));
        $display("rx pair left=%h right=%h", rx_left, rx_right);
      end
    end
    if (!Reset_h && tx_load) got_loads++;
  end

  initial begin
    pulse_reset();
    repeat (3) @(negedge Clk);

    // first left slot is not framed; its right slot has no partner
    rand_tx();
    frame(16'($urandom), 16'($urandom));

    tx_left  = 16'h1234;
    tx_right = 16'hFEDC;
    frame(16'hA5C3, 16'h8001);

    for (int i = 0; i < 4; i++) begin
      rand_tx();
      frame(16'($urandom), 16'($urandom));
    end

    // left slot cut short after 10 data bits
    rand_tx();
    slot(1'b0, 16'($urandom), 11, -1);
    slot(1'b1, 16'($urandom), SLOT, -1);
    check_eq("short_keep_left", 32'(rx_left), 32'(m_rxl));
    frame(16'h0F0F, 16'hF0F0);

    // reset in the middle of a left slot
    rand_tx();
    slot(1'b0, 16'($urandom), SLOT, 8);
    slot(1'b1, 16'($urandom), SLOT, -1);
    for (int i = 0; i < 2; i++) begin
      rand_tx();
      frame(16'($urandom), 16'($urandom));
    end

    // bit clock halves mid-run
    half = 326;
    for (int i = 0; i < 3; i++) begin
      rand_tx();
      frame(16'($urandom), 16'($urandom));
    end

`ifdef I2S_LOOPBACK_EN
    half  = 163;
    lb_on = 1'b1;
    frame(16'h7FFF, 16'h8000);
    rand_tx();
    frame(16'($urandom), 16'($urandom));
    lb_on = 1'b0;
    frame(16'($urandom), 16'($urandom));
`endif

    repeat (10) @(negedge Clk);
    check_eq("tx_load_count", 32'(got_loads), 32'(exp_loads));
    check_eq("rx_pending", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
